// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between the core load/store path and a host port.
// Define DMEM_ARB_STATS_EN to add saturating 16-bit grant/conflict counters.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4,
    parameter int HOST_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_stall,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_rvalid,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic [DATA_W-1:0] h_rdata,
    output logic              h_rvalid,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic [1:0]        owner
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_core_grants,
    output logic [15:0]       stat_host_grants,
    output logic [15:0]       stat_conflicts
`endif
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'b00,
        OWN_CORE = 2'b01,
        OWN_HOST = 2'b10
    } owner_e;

    localparam int              BW        = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]   BURST_MAX = BW'(MAX_BURST);

    owner_e              owner_q, owner_d;
    logic [BW-1:0]       burst_q, burst_d;
    logic                c_gnt_raw, h_gnt_raw;
    logic                c_rvalid_q, h_rvalid_q;
    logic [DATA_W-1:0]   c_rdata_q, h_rdata_q;

    // Grant decision; reset masks the grants so nothing reaches memory in a reset cycle.
    always_comb begin
        c_gnt_raw = 1'b0;
        h_gnt_raw = 1'b0;
        case ({c_req, h_req})
            2'b10: c_gnt_raw = 1'b1;
            2'b01: h_gnt_raw = 1'b1;
            2'b11: begin
                case (owner_q)
                    OWN_IDLE: begin
                        if (HOST_PRIO != 0) h_gnt_raw = 1'b1;
                        else                c_gnt_raw = 1'b1;
                    end
                    OWN_CORE: h_gnt_raw = 1'b1;
                    OWN_HOST: begin
                        if (burst_q < BURST_MAX) h_gnt_raw = 1'b1;
                        else                     c_gnt_raw = 1'b1;
                    end
                    default:  c_gnt_raw = 1'b1;
                endcase
            end
            default: ;
        endcase
        c_gnt = c_gnt_raw & ~reset;
        h_gnt = h_gnt_raw & ~reset;
    end

    always_comb begin
        owner_d = OWN_IDLE;
        burst_d = '0;
        if (h_gnt) begin
            owner_d = OWN_HOST;
            burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + 1'b1;
        end else if (c_gnt) begin
            owner_d = OWN_CORE;
        end
    end

    assign m_addr  = h_gnt ? h_addr  : c_addr;
    assign m_wdata = h_gnt ? h_wdata : c_wdata;
    assign m_we    = (c_gnt & c_we) | (h_gnt & h_we);
    assign c_stall = c_req & ~c_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q    <= OWN_IDLE;
            burst_q    <= '0;
            c_rvalid_q <= 1'b0;
            h_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            h_rdata_q  <= '0;
        end else begin
            owner_q    <= owner_d;
            burst_q    <= burst_d;
            c_rvalid_q <= c_gnt & ~c_we;
            h_rvalid_q <= h_gnt & ~h_we;
            if (c_gnt && !c_we) c_rdata_q <= m_rdata;
            if (h_gnt && !h_we) h_rdata_q <= m_rdata;
        end
    end

    assign owner    = owner_q;
    assign c_rdata  = c_rdata_q;
    assign c_rvalid = c_rvalid_q;
    assign h_rdata  = h_rdata_q;
    assign h_rvalid = h_rvalid_q;

`ifdef DMEM_ARB_STATS_EN
    logic [2:0]        stat_inc;
    logic [2:0][15:0]  stat_q, stat_d;

    assign stat_inc = {c_req & h_req, h_gnt, c_gnt};

    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
        assign stat_d[gi] = (stat_inc[gi] && stat_q[gi] != 16'hFFFF) ? stat_q[gi] + 16'd1 : stat_q[gi];
    end

    always_ff @(posedge clk) begin
        if (reset) stat_q <= '0;
        else       stat_q <= stat_d;
    end

    assign stat_core_grants = stat_q[0];
    assign stat_host_grants = stat_q[1];
    assign stat_conflicts   = stat_q[2];
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (MAX_BURST=4/HOST_PRIO=0 and MAX_BURST=1/HOST_PRIO=1)
// driven with the same requests, each with its own memory, checked against a per-cycle reference model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_we, h_req, h_we;
    logic [31:0] c_addr, c_wdata, h_addr, h_wdata;

    logic        c_gnt [2];
    logic        c_stall [2];
    logic [31:0] c_rdata [2];
    logic        c_rvalid [2];
    logic        h_gnt [2];
    logic [31:0] h_rdata [2];
    logic        h_rvalid [2];
    logic        m_we [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_rdata [2];
    logic [1:0]  owner [2];
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] sc [2];
    logic [15:0] sh [2];
    logic [15:0] sx [2];
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4), .HOST_PRIO(0)) dut_a (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt[0]), .c_stall(c_stall[0]), .c_rdata(c_rdata[0]), .c_rvalid(c_rvalid[0]),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt[0]), .h_rdata(h_rdata[0]), .h_rvalid(h_rvalid[0]),
        .m_we(m_we[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]), .m_rdata(m_rdata[0]),
        .owner(owner[0])
`ifdef DMEM_ARB_STATS_EN
        , .stat_core_grants(sc[0]), .stat_host_grants(sh[0]), .stat_conflicts(sx[0])
`endif
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(1), .HOST_PRIO(1)) dut_b (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt[1]), .c_stall(c_stall[1]), .c_rdata(c_rdata[1]), .c_rvalid(c_rvalid[1]),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt[1]), .h_rdata(h_rdata[1]), .h_rvalid(h_rvalid[1]),
        .m_we(m_we[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]), .m_rdata(m_rdata[1]),
        .owner(owner[1])
`ifdef DMEM_ARB_STATS_EN
        , .stat_core_grants(sc[1]), .stat_host_grants(sh[1]), .stat_conflicts(sx[1])
`endif
    );

    // Memory stand-ins: combinational read, write on the clock edge.
    logic [31:0] tbmem0 [64] = '{default: 32'h0};
    logic [31:0] tbmem1 [64] = '{default: 32'h0};
    assign m_rdata[0] = tbmem0[m_addr[0][5:0]];
    assign m_rdata[1] = tbmem1[m_addr[1][5:0]];
    always @(posedge clk) begin
        if (m_we[0]) tbmem0[m_addr[0][5:0]] <= m_wdata[0];
        if (m_we[1]) tbmem1[m_addr[1][5:0]] <= m_wdata[1];
    end

    // Reference model state (owner: 0 idle, 1 core, 2 host; run = consecutive host grants, capped)
    int          mb [2] = '{4, 1};
    int          hp [2] = '{0, 1};
    int          own [2];
    int          run [2];
    logic [31:0] mmem [2][64];
    logic [31:0] rd_c [2];
    logic [31:0] rd_h [2];
    bit          rv_c [2];
    bit          rv_h [2];
    int          st_c [2];
    int          st_h [2];
    int          st_x [2];
    string       gstr [2];
    int          wecnt [2];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    task automatic chk(string tag, int k, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic chk_s(string tag, int k, string obs, string exp);
        total++;
        assert (obs == exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%s expected=%s", tag, k, obs, exp);
        end
    endtask

    function automatic void decide(int k, bit cr, bit hr, output bit gc, output bit gh);
        gc = 1'b0;
        gh = 1'b0;
        if (cr && !hr)      gc = 1'b1;
        else if (hr && !cr) gh = 1'b1;
        else if (cr && hr) begin
            if (own[k] == 0) begin
                if (hp[k] != 0) gh = 1'b1; else gc = 1'b1;
            end else if (own[k] == 1) begin
                gh = 1'b1;
            end else if (run[k] < mb[k]) begin
                gh = 1'b1;
            end else begin
                gc = 1'b1;
            end
        end
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            own[k] = 0; run[k] = 0;
            rd_c[k] = '0; rd_h[k] = '0; rv_c[k] = 0; rv_h[k] = 0;
            st_c[k] = 0; st_h[k] = 0; st_x[k] = 0;
        end
    endtask

    task automatic cycle(bit rst, bit cr, bit cw, logic [31:0] ca, logic [31:0] cd,
                         bit hr, bit hw, logic [31:0] ha, logic [31:0] hd);
        bit gc [2];
        bit gh [2];
        string gch [2];
        reset = rst; c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        h_req = hr; h_we = hw; h_addr = ha; h_wdata = hd;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            decide(k, cr, hr, gc[k], gh[k]);
            if (rst) begin gc[k] = 1'b0; gh[k] = 1'b0; end
            chk("c_gnt", k, c_gnt[k], gc[k]);
            chk("h_gnt", k, h_gnt[k], gh[k]);
            chk("c_stall", k, c_stall[k], cr & ~gc[k]);
            chk("m_we", k, m_we[k], (gc[k] & cw) | (gh[k] & hw));
            chk("m_addr", k, m_addr[k], gh[k] ? ha : ca);
            chk("m_wdata", k, m_wdata[k], gh[k] ? hd : cd);
            chk("owner", k, owner[k], own[k]);
            chk("c_rvalid", k, c_rvalid[k], rv_c[k]);
            chk("c_rdata", k, c_rdata[k], rd_c[k]);
            chk("h_rvalid", k, h_rvalid[k], rv_h[k]);
            chk("h_rdata", k, h_rdata[k], rd_h[k]);
            gch[k] = gh[k] ? "H" : (gc[k] ? "C" : "-");
            gstr[k] = {gstr[k], gch[k]};
            if (m_we[k] === 1'b1) wecnt[k]++;
        end
        $display("cyc %0d rst=%0b creq=%0b hreq=%0b grantA=%s grantB=%s", cyc, rst, cr, hr, gch[0], gch[1]);
        cyc++;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                own[k] = 0; run[k] = 0;
                rd_c[k] = '0; rd_h[k] = '0; rv_c[k] = 0; rv_h[k] = 0;
                st_c[k] = 0; st_h[k] = 0; st_x[k] = 0;
            end else begin
                rv_c[k] = gc[k] & ~cw;
                rv_h[k] = gh[k] & ~hw;
                if (gh[k]) begin
                    if (hw) mmem[k][ha[5:0]] = hd; else rd_h[k] = mmem[k][ha[5:0]];
                end else if (gc[k]) begin
                    if (cw) mmem[k][ca[5:0]] = cd; else rd_c[k] = mmem[k][ca[5:0]];
                end
                own[k] = gh[k] ? 2 : (gc[k] ? 1 : 0);
                run[k] = gh[k] ? ((run[k] + 1 > mb[k]) ? mb[k] : run[k] + 1) : 0;
                if (gc[k] && st_c[k] < 65535) st_c[k]++;
                if (gh[k] && st_h[k] < 65535) st_h[k]++;
                if (cr && hr && st_x[k] < 65535) st_x[k]++;
            end
        end
        #1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 64; a++) mmem[k][a] = '0;
            gstr[k] = "";
            wecnt[k] = 0;
        end
        model_reset();
        reset = 1'b1; c_req = 1'b1; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        h_req = 1'b1; h_we = 1'b0; h_addr = '0; h_wdata = '0;
        @(posedge clk); #1;

        // Reset held two cycles with both requests high, then continuous contention
        cycle(1, 1, 0, 32'd5, 32'h0, 1, 0, 32'd6, 32'h0);
        cycle(1, 1, 0, 32'd5, 32'h0, 1, 0, 32'd6, 32'h0);
        chk_s("reset_grants", 0, gstr[0], "--");
        chk("owner_after_reset", 0, owner[0], 2'b00);
        gstr[0] = ""; gstr[1] = "";
        for (int i = 0; i < 11; i++) cycle(0, 1, 0, 32'(i), 32'h0, 1, 0, 32'(i + 20), 32'h0);
        chk_s("contention", 0, gstr[0], "CHHHHCHHHHC");
        chk_s("contention", 1, gstr[1], "HCHCHCHCHCH");

        // Host-only writes to 0..3, then a core read of address 2
        wecnt[0] = 0; wecnt[1] = 0;
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 32'h0, 32'h0, 1, 1, 32'(i), 32'hA0 + 32'(i));
        cycle(0, 1, 0, 32'd2, 32'h0, 0, 0, 32'h0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            chk("host_write_pulses", k, wecnt[k], 4);
            chk("core_read_valid", k, c_rvalid[k], 1'b1);
            chk("core_read_data", k, c_rdata[k], 32'h000000A2);
        end
        cycle(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        chk("rvalid_one_cycle", 0, c_rvalid[0], 1'b0);
        chk("rdata_hold", 0, c_rdata[0], 32'h000000A2);

        // Reset asserted during the third host cycle of a burst on instance A
        cycle(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 32'd40, 32'hC0 + 32'(i), 1, 1, 32'd41, 32'hD0 + 32'(i));
        wecnt[0] = 0;
        cycle(1, 1, 1, 32'd42, 32'hEE, 1, 1, 32'd43, 32'hFF);
        chk("reset_cycle_write", 0, wecnt[0], 0);
        chk("owner_after_midreset", 0, owner[0], 2'b00);
        gstr[0] = "";
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 32'd44, 32'h0, 1, 0, 32'd43, 32'h0);
        chk_s("burst_restart", 0, gstr[0], "CHHHHC");

        // Counter segment: one core-granted cycle then ten contention cycles from CORE
        cycle(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 11; i++) cycle(0, 1, 0, 32'(i), 32'h0, 1, 0, 32'(i + 8), 32'h0);
`ifdef DMEM_ARB_STATS_EN
        chk("stat_core", 0, sc[0], 16'd3);
        chk("stat_host", 0, sh[0], 16'd8);
        chk("stat_conf", 0, sx[0], 16'd11);
        for (int k = 0; k < 2; k++) begin
            chk("stat_core_model", k, sc[k], st_c[k]);
            chk("stat_host_model", k, sh[k], st_h[k]);
            chk("stat_conf_model", k, sx[k], st_x[k]);
        end
`endif

        // Randomized traffic with occasional reset
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 39) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  32'($urandom_range(0, 63)), $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  32'($urandom_range(0, 63)), $urandom);
        end
`ifdef DMEM_ARB_STATS_EN
        for (int k = 0; k < 2; k++) begin
            chk("stat_core_rand", k, sc[k], st_c[k]);
            chk("stat_host_rand", k, sh[k], st_h[k]);
            chk("stat_conf_rand", k, sx[k], st_x[k]);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
